// File: rtl/cpu_io_tx_pkg.sv
// cpu_io_tx shared types: FSM state encoding and field widths.
// SOF and the two gaps are single-state, single-cycle phases.
package cpu_io_tx_pkg;

    localparam int DEF_BYTE_W = 8;
    localparam int DEF_NIB_W  = 4;
    localparam int CNT_W      = 4;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SOF      = 3'd1,
        ST_SEND_B0  = 3'd2,
        ST_GAP0     = 3'd3,
        ST_SEND_B1  = 3'd4,
        ST_GAP1     = 3'd5,
        ST_SEND_NIB = 3'd6,
        ST_DONE     = 3'd7
    } tx_state_e;

    function automatic logic [CNT_W-1:0] last_idx(input int w);
        return CNT_W'(w - 1);
    endfunction

endpackage

// File: rtl/cpu_io_tx_if.sv
// Request/serial-output bundle between the CPU side and cpu_io_tx.
// master = requester (CPU or bench), slave = transmitter.
interface cpu_io_tx_if
    import cpu_io_tx_pkg::*;
#(
    parameter int BYTE_W = DEF_BYTE_W,
    parameter int NIB_W  = DEF_NIB_W
);
    logic              tx_start_i;
    logic [BYTE_W-1:0] byte0_i;
    logic [BYTE_W-1:0] byte1_i;
    logic [NIB_W-1:0]  nib_i;
    logic              tx_sof_o;
    logic              tx_bit_o;
    logic              tx_valid_o;
    logic              tx_busy_o;
    logic              tx_done_o;

    modport master (
        output tx_start_i, byte0_i, byte1_i, nib_i,
        input  tx_sof_o, tx_bit_o, tx_valid_o, tx_busy_o, tx_done_o
    );

    modport slave (
        input  tx_start_i, byte0_i, byte1_i, nib_i,
        output tx_sof_o, tx_bit_o, tx_valid_o, tx_busy_o, tx_done_o
    );
endinterface

// File: rtl/cpu_tx_shifter.sv
// Parallel-load shift register; ser_o is the bit currently at the
// outgoing edge, advanced by one position per shift_i.
module cpu_tx_shifter #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             shift_i,
    output logic             ser_o
);
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (load_i) begin
            data_d = data_i;
        end else if (shift_i) begin
            data_d = (MSB_FIRST != 0) ? (data_q << 1) : (data_q >> 1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign ser_o = (MSB_FIRST != 0) ? data_q[WIDTH-1] : data_q[0];
endmodule

// File: rtl/cpu_io_tx.sv
// Framed serial transmitter: SOF, byte0, gap, byte1, gap, nibble, done.
// Outputs decode only from registered state and shifter contents.
module cpu_io_tx
    import cpu_io_tx_pkg::*;
#(
    parameter int BYTE_W    = DEF_BYTE_W,
    parameter int NIB_W     = DEF_NIB_W,
    parameter int MSB_FIRST = 1
) (
    input logic         clk_i,
    input logic         rst_ni,
    cpu_io_tx_if.slave  tx
);
    localparam logic [CNT_W-1:0] B_LAST = last_idx(BYTE_W);
    localparam logic [CNT_W-1:0] N_LAST = last_idx(NIB_W);

    tx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             load;
    logic             ser_b0, ser_b1, ser_nib;

    assign load = (state_q == ST_IDLE) && tx.tx_start_i;

    cpu_tx_shifter #(.WIDTH(BYTE_W), .MSB_FIRST(MSB_FIRST)) u_sh_b0 (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .load_i  (load),
        .data_i  (tx.byte0_i),
        .shift_i (state_q == ST_SEND_B0),
        .ser_o   (ser_b0)
    );

    cpu_tx_shifter #(.WIDTH(BYTE_W), .MSB_FIRST(MSB_FIRST)) u_sh_b1 (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .load_i  (load),
        .data_i  (tx.byte1_i),
        .shift_i (state_q == ST_SEND_B1),
        .ser_o   (ser_b1)
    );

    cpu_tx_shifter #(.WIDTH(NIB_W), .MSB_FIRST(MSB_FIRST)) u_sh_nib (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .load_i  (load),
        .data_i  (tx.nib_i),
        .shift_i (state_q == ST_SEND_NIB),
        .ser_o   (ser_nib)
    );

    // Counter only runs inside SEND states; every other state clears it.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        case (state_q)
            ST_IDLE:     if (tx.tx_start_i) state_d = ST_SOF;
            ST_SOF:      state_d = ST_SEND_B0;
            ST_SEND_B0:
                if (cnt_q == B_LAST) state_d = ST_GAP0;
                else                 cnt_d   = cnt_q + 1'b1;
            ST_GAP0:     state_d = ST_SEND_B1;
            ST_SEND_B1:
                if (cnt_q == B_LAST) state_d = ST_GAP1;
                else                 cnt_d   = cnt_q + 1'b1;
            ST_GAP1:     state_d = ST_SEND_NIB;
            ST_SEND_NIB:
                if (cnt_q == N_LAST) state_d = ST_DONE;
                else                 cnt_d   = cnt_q + 1'b1;
            ST_DONE:     state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        tx.tx_sof_o   = 1'b0;
        tx.tx_bit_o   = 1'b0;
        tx.tx_valid_o = 1'b0;
        tx.tx_busy_o  = 1'b1;
        tx.tx_done_o  = 1'b0;
        case (state_q)
            ST_IDLE:     tx.tx_busy_o = 1'b0;
            ST_SOF:      tx.tx_sof_o  = 1'b1;
            ST_SEND_B0:  begin tx.tx_valid_o = 1'b1; tx.tx_bit_o = ser_b0;  end
            ST_SEND_B1:  begin tx.tx_valid_o = 1'b1; tx.tx_bit_o = ser_b1;  end
            ST_SEND_NIB: begin tx.tx_valid_o = 1'b1; tx.tx_bit_o = ser_nib; end
            ST_DONE:     tx.tx_done_o = 1'b1;
            ST_GAP0, ST_GAP1: ;
            default:     tx.tx_busy_o = 1'b0;
        endcase
    end
endmodule

// File: tb/tb_cpu_io_tx.sv
// Directed + random bench for cpu_io_tx with a serial loader model.
module tb_cpu_io_tx;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    cpu_io_tx_if #(.BYTE_W(8), .NIB_W(4)) tif ();

    cpu_io_tx #(.BYTE_W(8), .NIB_W(4), .MSB_FIRST(1)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .tx     (tif)
    );

    logic [4:0] obs;
    assign obs = {tif.tx_sof_o, tif.tx_valid_o, tif.tx_bit_o,
                  tif.tx_busy_o, tif.tx_done_o};

    // Receiver model: sof restarts, valid bits accumulate MSB first.
    logic [19:0] rx_q[$];
    logic [19:0] rx_v = '0;
    int          rx_n = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            rx_n <= 0;
        end else if (tif.tx_sof_o) begin
            rx_n <= 0;
            rx_v <= '0;
        end else if (tif.tx_valid_o) begin
            rx_v <= {rx_v[18:0], tif.tx_bit_o};
            rx_n <= rx_n + 1;
            if (rx_n == 19) rx_q.push_back({rx_v[18:0], tif.tx_bit_o});
        end
    end

    task automatic chk(input string tag, input logic [31:0] o,
                       input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected {sof,valid,bit,busy,done} in cycle k of a frame f={b0,b1,nib}.
    function automatic logic [4:0] exp_out(input int k, input logic [19:0] f);
        logic s, v, b, bz, d;
        int   idx;
        s = 0; v = 0; b = 0; bz = 0; d = 0; idx = -1;
        if (k >= 1 && k <= 24) bz = 1;
        if (k == 1) s = 1;
        if (k >= 2 && k <= 9)        idx = k - 2;
        else if (k >= 11 && k <= 18) idx = k - 3;
        else if (k >= 20 && k <= 23) idx = k - 4;
        if (idx >= 0) begin
            v = 1;
            b = f[19 - idx];
        end
        if (k == 24) d = 1;
        return {s, v, b, bz, d};
    endfunction

    // Modes: 0 plain, 1 change inputs after E0, 2 start pulses while
    // busy, 3 keep start high. Entered and left in an IDLE cycle.
    task automatic run_frame(input logic [7:0] b0, input logic [7:0] b1,
                             input logic [3:0] nb, input int mode,
                             input string tag);
        logic [19:0] f;
        int          n0;
        f  = {b0, b1, nb};
        n0 = rx_q.size();
        tif.byte0_i    = b0;
        tif.byte1_i    = b1;
        tif.nib_i      = nb;
        tif.tx_start_i = 1'b1;
        tick();
        if (mode != 3) tif.tx_start_i = 1'b0;
        if (mode == 1) begin
            tif.byte0_i = 8'hFF;
            tif.byte1_i = 8'h00;
            tif.nib_i   = ~nb;
        end
        for (int k = 1; k <= 25; k++) begin
            chk($sformatf("%s k=%0d", tag, k), 32'(obs), 32'(exp_out(k, f)));
            if (mode == 2) tif.tx_start_i = (k == 5 || k == 15);
            if (k < 25) tick();
        end
        chk({tag, " rx count"}, rx_q.size(), n0 + 1);
        if (rx_q.size() > n0) chk({tag, " rx data"}, 32'(rx_q[$]), 32'(f));
        if (mode == 2) begin
            tick();
            chk({tag, " no queued start"}, 32'(obs), 32'h0);
        end
    endtask

    initial begin
        int n0;
        tif.tx_start_i = 1'b1;
        tif.byte0_i    = 8'h5A;
        tif.byte1_i    = 8'hC3;
        tif.nib_i      = 4'h6;
        repeat (3) tick();
        chk("reset outputs", 32'(obs), 32'h0);
        tif.tx_start_i = 1'b0;
        rst_n = 1'b1;
        tick();
        chk("idle after reset", 32'(obs), 32'h0);

        run_frame(8'hA5, 8'h3C, 4'h9, 0, "basic");
        run_frame(8'hA5, 8'h3C, 4'h9, 1, "snapshot");
        run_frame(8'h81, 8'h7E, 4'h3, 2, "busy start");

        run_frame(8'h12, 8'h34, 4'h5, 3, "held1");
        run_frame(8'hF0, 8'h0F, 4'hA, 3, "held2");
        run_frame(8'hCC, 8'h33, 4'hF, 0, "held3");

        tif.byte0_i    = 8'hDE;
        tif.byte1_i    = 8'hAD;
        tif.nib_i      = 4'hB;
        tif.tx_start_i = 1'b1;
        tick();
        tif.tx_start_i = 1'b0;
        n0 = rx_q.size();
        repeat (11) tick();
        chk("pre-reset busy k=12", 32'(tif.tx_busy_o), 32'h1);
        rst_n = 1'b0;
        tick();
        chk("mid-frame reset", 32'(obs), 32'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 14; i++) begin
            tick();
            chk($sformatf("aborted idle %0d", i), 32'(obs), 32'h0);
        end
        chk("aborted rx count", rx_q.size(), n0);
        run_frame(8'h5C, 8'hE1, 4'h7, 0, "after reset");

        for (int i = 0; i < 100; i++) begin
            run_frame(8'($urandom), 8'($urandom), 4'($urandom), 0,
                      $sformatf("rand%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
